// File: rtl/gate_chk_pkg.sv
// Shared definitions for the basic-gate self-check flow: gate bit order, default width and
// checker FSM encoding.
package gate_chk_pkg;

  localparam int unsigned N_GATES_DFLT = 7;

  localparam int unsigned G_AND  = 0;
  localparam int unsigned G_OR   = 1;
  localparam int unsigned G_NOT  = 2;
  localparam int unsigned G_NAND = 3;
  localparam int unsigned G_NOR  = 4;
  localparam int unsigned G_XOR  = 5;
  localparam int unsigned G_XNOR = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } gate_chk_state_e;

endpackage

// File: rtl/gate_golden.sv
// Golden truth table for the seven basic gates; purely combinational and shared with the
// stimulus side.
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic                    a_i,
  input  logic                    b_i,
  output logic [N_GATES_DFLT-1:0] exp_o
);

  always_comb begin
    exp_o         = '0;
    exp_o[G_AND]  = a_i & b_i;
    exp_o[G_OR]   = a_i | b_i;
    exp_o[G_NOT]  = ~a_i;
    exp_o[G_NAND] = ~(a_i & b_i);
    exp_o[G_NOR]  = ~(a_i | b_i);
    exp_o[G_XOR]  = a_i ^ b_i;
    exp_o[G_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_result_checker.sv
// Receives (a, b, result) samples over valid/ready, compares them against the golden gate
// table and accumulates per-gate and total errors over a run of NUM_VECTORS samples.
module gate_result_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned N_GATES     = N_GATES_DFLT,
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_a,
  input  logic               in_b,
  input  logic [N_GATES-1:0] in_res,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] err_mask,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   first_err_idx
);

  // Sample counter is widened when a run is longer than the reported counters can express.
  localparam int unsigned NvW  = $clog2(NUM_VECTORS + 1);
  localparam int unsigned SmpW = (CNT_W > NvW) ? CNT_W : NvW;

  gate_chk_state_e     state_q, state_d;
  logic [SmpW-1:0]     counter_q, counter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_GATES-1:0]  err_mask_q, err_mask_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CNT_W-1:0]    first_err_q, first_err_d;

  logic [N_GATES_DFLT-1:0] golden;
  logic [N_GATES-1:0]      exp_vec;
  logic [N_GATES-1:0]      mism;
  logic                    accept;

  gate_golden u_golden (
    .a_i   (in_a),
    .b_i   (in_b),
    .exp_o (golden)
  );

  assign exp_vec  = N_GATES'(golden);
  assign in_ready = (state_q == StRun);
  assign accept   = in_valid & in_ready;

  // Case inequality so that X/Z on an observed output counts as a mismatch in simulation.
  always_comb begin
    mism = '0;
    for (int i = 0; i < int'(N_GATES); i++) begin
      mism[i] = (exp_vec[i] !== in_res[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          counter_d   = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_mask_d  = '0;
          err_count_d = '0;
          first_err_d = '1;
        end
      end
      StRun: begin
        if (accept) begin
          err_mask_d = err_mask_q | mism;
          if (|mism) begin
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (first_err_q == '1) first_err_d = counter_q[CNT_W-1:0];
          end
          counter_d = counter_q + 1'b1;
          if (counter_q == SmpW'(NUM_VECTORS - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      counter_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_mask_q  <= '0;
      err_count_q <= '0;
      first_err_q <= '1;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_mask      = err_mask_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Directed, table-driven bench for gate_result_checker, with a second instance sized for
// counter saturation over a long run.
module tb_gate_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, in_valid, in_a, in_b;
  logic [6:0] in_res;
  logic       in_ready, busy, done, pass;
  logic [6:0] err_mask;
  logic [7:0] err_count, first_err_idx;

  logic       s_start, s_valid, s_a, s_b;
  logic [6:0] s_res;
  logic       s_ready, s_busy, s_done, s_pass;
  logic [6:0] s_mask;
  logic [7:0] s_count, s_first;

  gate_result_checker #(.N_GATES(7), .NUM_VECTORS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_res(in_res), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  gate_result_checker #(.N_GATES(7), .NUM_VECTORS(300), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_res(s_res), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_mask(s_mask), .err_count(s_count), .first_err_idx(s_first)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Correct outputs {xnor,xor,nor,nand,not,or,and} for ab = 00, 01, 10, 11.
  logic [6:0] gold [4];

  typedef struct {
    string          name;
    logic [3:0][6:0] res;
    bit             gaps;
    logic [6:0]     mask;
    logic [7:0]     cnt;
    logic [7:0]     first;
    logic           pass;
  } run_t;

  run_t runs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
    chk({tag, " err_mask"}, 32'(err_mask), 32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
    chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'hFF);
  endtask

  // Holds valid for exactly one clock edge; returns 1 time unit after that edge.
  task automatic send(input logic a, input logic b, input logic [6:0] res);
    in_a = a; in_b = b; in_res = res; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_end(input run_t r);
    @(negedge clk);
    chk({r.name, " done"}, 32'(done), 32'd1);
    chk({r.name, " busy"}, 32'(busy), 32'd0);
    chk({r.name, " in_ready"}, 32'(in_ready), 32'd0);
    chk({r.name, " pass"}, 32'(pass), 32'(r.pass));
    chk({r.name, " err_mask"}, 32'(err_mask), 32'(r.mask));
    chk({r.name, " err_count"}, 32'(err_count), 32'(r.cnt));
    chk({r.name, " first_err_idx"}, 32'(first_err_idx), 32'(r.first));
  endtask

  task automatic do_run(input run_t r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({r.name, " busy after start"}, 32'(busy), 32'd1);
    chk({r.name, " in_ready after start"}, 32'(in_ready), 32'd1);
    for (int s = 0; s < 4; s++) begin
      if (r.gaps) begin
        in_valid = 1'b0;
        start = (s == 2);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
      end
      if (s == 3) begin
        @(negedge clk);
        chk({r.name, " done before last"}, 32'(done), 32'd0);
      end
      send(s[1], s[0], r.res[s]);
    end
    check_end(r);
  endtask

  initial begin
    gold[0] = 7'b1011100;
    gold[1] = 7'b0101110;
    gold[2] = 7'b0101010;
    gold[3] = 7'b1000011;

    runs[0] = '{"clean", {gold[3], gold[2], gold[1], gold[0]}, 1'b0,
                7'h00, 8'd0, 8'hFF, 1'b1};
    runs[1] = '{"xor_fault", {gold[3], gold[2], gold[1] ^ 7'b0100000, gold[0]}, 1'b0,
                7'b0100000, 8'd1, 8'd1, 1'b0};
    runs[2] = '{"multi_fault", {gold[3] ^ 7'b0001100, gold[2], gold[1], gold[0] ^ 7'b0000001},
                1'b0, 7'b0001101, 8'd2, 8'd0, 1'b0};
    runs[3] = '{"or_fault", {gold[3] ^ 7'b0000010, gold[2] ^ 7'b0000010, gold[1], gold[0]},
                1'b0, 7'b0000010, 8'd2, 8'd2, 1'b0};
    runs[4] = '{"all_wrong", {~gold[3], ~gold[2], ~gold[1], ~gold[0]}, 1'b0,
                7'h7F, 8'd4, 8'd0, 1'b0};
    runs[5] = '{"gaps", {gold[3], gold[2], gold[1], gold[0]}, 1'b1,
                7'h00, 8'd0, 8'hFF, 1'b1};

    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_res = '0;
    s_start = 1'b0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_res = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("in_reset");
    #4 rst_n = 1'b1;

    // Idle with valid asserted and no start: nothing is accepted.
    in_valid = 1'b1; in_res = 7'h55;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("idle_valid");
    in_valid = 1'b0;
    @(posedge clk); #1;

    foreach (runs[i]) do_run(runs[i]);

    // Start from DONE with a bad sample valid on the same cycle: that sample is dropped.
    start = 1'b1; in_valid = 1'b1; in_a = 1'b0; in_b = 1'b0; in_res = ~gold[0];
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < 4; s++) send(s[1], s[0], gold[s]);
    check_end(runs[0]);

    // Reset mid-run after two accepts, one of them wrong.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(1'b0, 1'b0, ~gold[0]);
    send(1'b0, 1'b1, gold[1]);
    @(negedge clk);
    chk("pre_reset err_count", 32'(err_count), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_run_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(runs[0]);

    // Saturation: 300 samples, all wrong.
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s_a = 1'((i % 4) >> 1); s_b = 1'(i % 2); s_res = ~gold[i % 4]; s_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 298) chk("sat done before last", 32'(s_done), 32'd0);
      if (i == 254) chk("sat count at 255 errors", 32'(s_count), 32'd255);
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("sat done", 32'(s_done), 32'd1);
    chk("sat busy", 32'(s_busy), 32'd0);
    chk("sat pass", 32'(s_pass), 32'd0);
    chk("sat err_count", 32'(s_count), 32'd255);
    chk("sat first_err_idx", 32'(s_first), 32'd0);
    chk("sat err_mask", 32'(s_mask), 32'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
